// File: rtl/ram_dump_pkg.sv
// Shared types for the RAM dump engine: FSM states and the buffered word record.
package ram_dump_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;

   localparam int FifoDepth = 2;

   // Entry fields are sized for the widest supported build (Width <= 64, Depth <= 65536).
   localparam int MaxWidth = 64;
   localparam int MaxAw    = 16;

   typedef struct packed {
      logic [MaxWidth-1:0] data;
      logic [MaxAw-1:0]    addr;
      logic                last;
   } dump_entry_t;

endpackage

// File: rtl/ram_dump_fifo2.sv
// Two-entry synchronous FIFO of dump entries; head is always visible on dout_o.
module ram_dump_fifo2
   import ram_dump_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        push_i,
   input  dump_entry_t din_i,
   input  logic        pop_i,
   input  logic        flush_i,
   output dump_entry_t dout_o,
   output logic [1:0]  count_o,
   output logic        full_o,
   output logic        empty_o
);

   dump_entry_t mem_reg [FifoDepth];
   logic        wr_ptr_reg;
   logic        rd_ptr_reg;
   logic [1:0]  count_reg;
   logic        do_push;
   logic        do_pop;

   assign empty_o = (count_reg == 2'd0);
   assign full_o  = (count_reg == 2'(FifoDepth));
   assign count_o = count_reg;
   assign dout_o  = mem_reg[rd_ptr_reg];

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < FifoDepth; i++) begin
            mem_reg[i] <= '0;
         end
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else if (flush_i) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_reg[wr_ptr_reg] <= din_i;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (do_pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/ram_1p_dump.sv
// Sweeps a single-port RAM from address 0 to Depth-1 and streams each word with its
// address on a valid/ready port, throttling reads so the 2-entry buffer never overflows.
module ram_1p_dump
   import ram_dump_pkg::*;
#(
   parameter  int Width = 32,
   parameter  int Depth = 128,
   localparam int Aw    = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             ram_req_o,
   output logic [Aw-1:0]    ram_addr_o,
   input  logic [Width-1:0] ram_rdata_i,
   output logic             dump_valid_o,
   input  logic             dump_ready_i,
   output logic [Width-1:0] dump_data_o,
   output logic [Aw-1:0]    dump_addr_o,
   output logic             dump_last_o
);

   localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

   state_e          state_reg;
   state_e          state_next;
   logic [Aw-1:0]   cnt_reg;
   logic [Aw-1:0]   addr_q_reg;
   logic            inflight_reg;
   logic            issue;
   logic            done;
   logic            pop;
   logic [2:0]      occupancy;
   dump_entry_t     push_entry;
   dump_entry_t     head;
   logic [1:0]      fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic            unused_bits;

   assign pop = !fifo_empty && dump_ready_i;

   // Slots committed after this edge; a same-cycle pop frees its slot, which keeps
   // one word per cycle flowing while the buffer stays within two entries.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      done       = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (start_i) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (occupancy < 3'd2) begin
               issue = 1'b1;
               if (cnt_reg == LastAddr) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && head.last) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (abort_i) begin
         state_next = IDLE;
         issue      = 1'b0;
         done       = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         addr_q_reg   <= '0;
         inflight_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         inflight_reg <= issue;
         if (issue) begin
            addr_q_reg <= cnt_reg;
         end
         if (state_next == IDLE) begin
            cnt_reg <= '0;
         end else if (issue && (cnt_reg != LastAddr)) begin
            cnt_reg <= cnt_reg + Aw'(1);
         end
      end
   end

   assign push_entry = '{
      data: MaxWidth'(ram_rdata_i),
      addr: MaxAw'(addr_q_reg),
      last: (addr_q_reg == LastAddr)
   };

   ram_dump_fifo2 u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (inflight_reg),
      .din_i   (push_entry),
      .pop_i   (pop),
      .flush_i (abort_i),
      .dout_o  (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Upper entry bits beyond Width/Aw are always zero and intentionally dropped.
   assign unused_bits = ^{head, fifo_full};

   assign busy_o       = (state_reg != IDLE);
   assign done_o       = done;
   assign ram_req_o    = issue;
   assign ram_addr_o   = cnt_reg;
   assign dump_valid_o = !fifo_empty;
   assign dump_data_o  = head.data[Width-1:0];
   assign dump_addr_o  = head.addr[Aw-1:0];
   assign dump_last_o  = head.last;

endmodule

// File: tb/tb_ram_1p_dump.sv
// Bench for ram_1p_dump: a registered-read RAM model feeds the DUT; accepted words are
// collected per cycle and compared against the contents the bench itself loaded.
module tb_ram_1p_dump;

   localparam int W  = 32;
   localparam int D  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          ready = 1'b0;
   logic          busy, done, ram_req, dump_valid, dump_last;
   logic [AW-1:0] ram_addr, dump_addr;
   logic [W-1:0]  ram_rdata, dump_data;

   logic [W-1:0]  ram_mem [D];
   logic [W-1:0]  exp_mem [D];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_req) ram_rdata <= ram_mem[ram_addr];
   end

   ram_1p_dump #(.Width(W), .Depth(D)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .abort_i      (abort),
      .busy_o       (busy),
      .done_o       (done),
      .ram_req_o    (ram_req),
      .ram_addr_o   (ram_addr),
      .ram_rdata_i  (ram_rdata),
      .dump_valid_o (dump_valid),
      .dump_ready_i (ready),
      .dump_data_o  (dump_data),
      .dump_addr_o  (dump_addr),
      .dump_last_o  (dump_last)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [W-1:0] acc_data [$];
   int           acc_addr [$];
   bit           acc_last [$];
   int           acc_cyc  [$];
   int           done_cnt, done_cyc, req_cnt, ovf, stab_err, out_cnt;
   bit           prev_hold;
   logic [W-1:0] prev_data;
   logic [AW-1:0] prev_addr;

   task automatic clear_mon();
      acc_data.delete(); acc_addr.delete(); acc_last.delete(); acc_cyc.delete();
      done_cnt = 0; done_cyc = -1; req_cnt = 0; ovf = 0; stab_err = 0; out_cnt = 0;
      prev_hold = 1'b0;
   endtask

   task automatic preload();
      for (int i = 0; i < D; i++) begin
         ram_mem[i] = 32'hA500_0000 | i;
         exp_mem[i] = 32'hA500_0000 | i;
      end
   endtask

   // One clock cycle: sample at the falling edge, then step past the rising edge.
   task automatic tick();
      @(negedge clk);
      if (rst_n) begin
         if (prev_hold && (!dump_valid || dump_data !== prev_data || dump_addr !== prev_addr))
            stab_err++;
         if (dump_valid && ready) begin
            acc_data.push_back(dump_data);
            acc_addr.push_back(int'(dump_addr));
            acc_last.push_back(dump_last);
            acc_cyc.push_back(cyc);
            $display("txn cyc=%0d addr=%0d data=%h last=%0b", cyc, dump_addr, dump_data, dump_last);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (ram_req) req_cnt++;
         out_cnt += int'(ram_req) - int'(dump_valid && ready);
         if (out_cnt > 2) ovf++;
         if (abort) out_cnt = 0;
         prev_hold = dump_valid && !ready && !abort;
         prev_data = dump_data;
         prev_addr = dump_addr;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic pulse_start(output int sc);
      start = 1'b1;
      sc = cyc;
      tick();
      start = 1'b0;
   endtask

   // mode 0: ready high, 1: ready toggles 1010..., 2: random ready
   task automatic run_dump(input int mode, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         case (mode)
            0: ready = 1'b1;
            1: ready = (cyc % 2 == 0);
            default: ready = ($urandom_range(0, 3) != 0);
         endcase
         tick();
         n++;
      end
      ready = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({busy, done, ram_req, dump_valid, dump_last, ram_addr, dump_addr, dump_data} !== '0) begin
         bad++;
         $display("FAIL reset_hold got busy=%b done=%b req=%b valid=%b data=%h want all 0",
                  busy, done, ram_req, dump_valid, dump_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({busy, done, ram_req, dump_valid, ram_addr} !== '0) begin
         bad++;
         $display("FAIL reset_release got busy=%b req=%b valid=%b addr=%0d want 0", busy, ram_req, dump_valid, ram_addr);
      end
   endtask

   task automatic test_full_speed();
      int sc;
      preload();
      clear_mon();
      ready = 1'b1;
      pulse_start(sc);
      run_dump(0, 40);
      total++;
      if (acc_data.size() != D) begin bad++; $display("FAIL t1_count got=%0d want=%0d", acc_data.size(), D); end
      for (int i = 0; i < acc_data.size() && i < D; i++) begin
         total++;
         if (acc_data[i] !== exp_mem[i] || acc_addr[i] != i || acc_last[i] != (i == D - 1)) begin
            bad++;
            $display("FAIL t1_word%0d got=%h/%0d/%0b want=%h/%0d/%0b", i, acc_data[i], acc_addr[i], acc_last[i], exp_mem[i], i, i == D - 1);
         end
      end
      total++;
      if (done_cnt != 1 || done_cyc - sc != 10) begin
         bad++;
         $display("FAIL t1_done got count=%0d at=+%0d want count=1 at=+10", done_cnt, done_cyc - sc);
      end
      total++;
      if (acc_cyc.size() == 0 || acc_cyc[0] - sc != 3) begin
         bad++;
         $display("FAIL t1_first_valid got=+%0d want=+3", acc_cyc.size() ? acc_cyc[0] - sc : -1);
      end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_after got=%b want=0", busy); end
   endtask

   task automatic test_toggle_ready();
      int sc;
      preload();
      clear_mon();
      pulse_start(sc);
      run_dump(1, 80);
      total++;
      if (acc_data.size() != D) begin bad++; $display("FAIL t2_count got=%0d want=%0d", acc_data.size(), D); end
      for (int i = 0; i < acc_data.size() && i < D; i++) begin
         total++;
         if (acc_data[i] !== exp_mem[i] || acc_addr[i] != i || acc_last[i] != (i == D - 1)) begin
            bad++;
            $display("FAIL t2_word%0d got=%h/%0d/%0b want=%h/%0d/%0b", i, acc_data[i], acc_addr[i], acc_last[i], exp_mem[i], i, i == D - 1);
         end
      end
      total++;
      if (stab_err != 0 || ovf != 0 || done_cnt != 1) begin
         bad++;
         $display("FAIL t2_flow got stab=%0d ovf=%0d done=%0d want 0/0/1", stab_err, ovf, done_cnt);
      end
   endtask

   task automatic test_backpressure();
      int sc;
      preload();
      clear_mon();
      ready = 1'b0;
      pulse_start(sc);
      repeat (20) tick();
      total++;
      if (req_cnt != 2 || dump_valid !== 1'b1 || dump_data !== exp_mem[0]) begin
         bad++;
         $display("FAIL t3_stall got reqs=%0d valid=%b data=%h want reqs=2 valid=1 data=%h", req_cnt, dump_valid, dump_data, exp_mem[0]);
      end
      run_dump(0, 40);
      total++;
      if (acc_data.size() != D) begin bad++; $display("FAIL t3_count got=%0d want=%0d", acc_data.size(), D); end
      for (int i = 0; i < acc_data.size() && i < D; i++) begin
         total++;
         if (acc_data[i] !== exp_mem[i] || acc_addr[i] != i) begin
            bad++;
            $display("FAIL t3_word%0d got=%h/%0d want=%h/%0d", i, acc_data[i], acc_addr[i], exp_mem[i], i);
         end
      end
      total++;
      if (stab_err != 0 || ovf != 0) begin bad++; $display("FAIL t3_flow got stab=%0d ovf=%0d want 0/0", stab_err, ovf); end
   endtask

   task automatic test_abort();
      int sc;
      int n = 0;
      preload();
      clear_mon();
      ready = 1'b1;
      pulse_start(sc);
      while (acc_data.size() < 3 && n < 30) begin tick(); n++; end
      abort = 1'b1;
      ready = 1'b0;
      tick();
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || dump_valid !== 1'b0) begin
         bad++;
         $display("FAIL t4_abort got busy=%b valid=%b want 0/0", busy, dump_valid);
      end
      req_cnt = 0;
      ready = 1'b1;
      repeat (10) tick();
      total++;
      if (done_cnt != 0 || req_cnt != 0) begin
         bad++;
         $display("FAIL t4_quiet got done=%0d reqs=%0d want 0/0", done_cnt, req_cnt);
      end
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL t4_abort_wins got busy=%b want=0", busy); end
      clear_mon();
      pulse_start(sc);
      run_dump(0, 40);
      total++;
      if (acc_data.size() != D) begin bad++; $display("FAIL t4_count got=%0d want=%0d", acc_data.size(), D); end
      for (int i = 0; i < acc_data.size() && i < D; i++) begin
         total++;
         if (acc_data[i] !== exp_mem[i] || acc_addr[i] != i) begin
            bad++;
            $display("FAIL t4_word%0d got=%h/%0d want=%h/%0d", i, acc_data[i], acc_addr[i], exp_mem[i], i);
         end
      end
   endtask

   task automatic test_start_ignored();
      int sc;
      preload();
      clear_mon();
      ready = 1'b1;
      pulse_start(sc);
      for (int n = 0; n < 25; n++) begin
         start = (cyc - sc == 3) || (cyc - sc == 6) || (cyc - sc == 10);
         tick();
      end
      start = 1'b0;
      total++;
      if (acc_data.size() != D || done_cnt != 1 || done_cyc - sc != 10 || busy !== 1'b0) begin
         bad++;
         $display("FAIL t5_single got words=%0d done=%0d at=+%0d busy=%b want 8/1/+10/0", acc_data.size(), done_cnt, done_cyc - sc, busy);
      end
   endtask

   task automatic test_reset_mid();
      int sc;
      preload();
      clear_mon();
      ready = 1'b1;
      pulse_start(sc);
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, ram_req, dump_valid, dump_last, ram_addr, dump_addr, dump_data} !== '0) begin
         bad++;
         $display("FAIL t6_async got busy=%b req=%b valid=%b addr=%0d data=%h want all 0", busy, ram_req, dump_valid, ram_addr, dump_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      clear_mon();
      pulse_start(sc);
      run_dump(0, 40);
      total++;
      if (acc_data.size() != D || done_cnt != 1) begin
         bad++;
         $display("FAIL t6_count got words=%0d done=%0d want %0d/1", acc_data.size(), done_cnt, D);
      end
      for (int i = 0; i < acc_data.size() && i < D; i++) begin
         total++;
         if (acc_data[i] !== exp_mem[i] || acc_addr[i] != i) begin
            bad++;
            $display("FAIL t6_word%0d got=%h/%0d want=%h/%0d", i, acc_data[i], acc_addr[i], exp_mem[i], i);
         end
      end
   endtask

   task automatic test_random();
      int sc;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < D; i++) begin
            ram_mem[i] = $urandom;
            exp_mem[i] = ram_mem[i];
         end
         clear_mon();
         pulse_start(sc);
         run_dump(2, 300);
         total++;
         if (acc_data.size() != D || done_cnt != 1 || stab_err != 0 || ovf != 0) begin
            bad++;
            $display("FAIL rnd%0d_flow got words=%0d done=%0d stab=%0d ovf=%0d want %0d/1/0/0", r, acc_data.size(), done_cnt, stab_err, ovf, D);
         end
         for (int i = 0; i < acc_data.size() && i < D; i++) begin
            total++;
            if (acc_data[i] !== exp_mem[i] || acc_addr[i] != i || acc_last[i] != (i == D - 1)) begin
               bad++;
               $display("FAIL rnd%0d_word%0d got=%h/%0d/%0b want=%h/%0d/%0b", r, i, acc_data[i], acc_addr[i], acc_last[i], exp_mem[i], i, i == D - 1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_speed();
      test_toggle_ready();
      test_backpressure();
      test_abort();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
